cpu_useq: RTL and testbench
===========================

Name: cpu_useq

Overview:
Parametrised micro-sequencer that owns the CPU control FSM state register and a hardware return stack. It replaces the fixed three-field state/return/level record with a configurable-depth call stack, a stall input for motherboard handshakes, and sticky halt and fault reporting. The CPU combinational decode drives one command per cycle. The sequencer registers the next state and feeds it back to the decode logic and to the debug display.

Parameters:
STATE_WIDTH, 8, width of a control-state code
STACK_DEPTH, 4, number of return-stack entries (>=1)
RESET_STATE, 0, state code loaded on reset
FAULT_STATE, 8'hFF, state code forced on any fault
LEVEL_WIDTH, $clog2(STACK_DEPTH+1), width of stack_level

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd  in  3  000 HOLD, 001 NEXT, 010 CALL, 011 RET, 100 HALT, 101-111 illegal
cmd_target  in  STATE_WIDTH  destination state for NEXT/CALL
cmd_ret  in  STATE_WIDTH  return state pushed by CALL
stall  in  1  motherboard busy; freezes the sequencer
state_out  out  STATE_WIDTH  current control state
stack_level  out  LEVEL_WIDTH  number of valid stack entries
stack_top  out  STATE_WIDTH  top entry, or 0 when the stack is empty
halted  out  1  sticky halt flag
fault  out  1  sticky fault flag
fault_code  out  2  0 none, 1 overflow, 2 underflow, 3 illegal cmd
step_pulse  out  1  1-cycle pulse for each accepted command other than HOLD

Behaviour:
- All outputs are registered. A command sampled at edge N is visible on the outputs after edge N.
- Reset: clk is the only clock; rst is sampled on the rising edge of clk and has top priority.
  - state_out=RESET_STATE, stack_level=0, stack_top=0, halted=0, fault=0, fault_code=0, step_pulse=0.
  - Stack RAM contents are don't-care after reset.
- Reset asserted mid-call discards all stack entries.
- Priority after reset: fault, then halted, then stall, then cmd.
- fault=1: everything is frozen, except that step_pulse is 0. Exit is by rst only.
- halted=1: everything is frozen. Exit is by rst only.
- stall=1: all registers hold and step_pulse=0. The cmd is not consumed; the decoder holds cmd stable until stall drops.
- HOLD: no change, step_pulse=0.
- NEXT: state_out<=cmd_target.
- CALL with stack_level<STACK_DEPTH:
  - stack[stack_level]<=cmd_ret, stack_level+=1, state_out<=cmd_target.
- CALL with stack_level==STACK_DEPTH (overflow):
  - state_out<=FAULT_STATE, fault<=1, fault_code<=1.
  - Stack and level are unchanged.
- RET with stack_level>0:
  - state_out<=stack[stack_level-1], stack_level-=1.
- RET with stack_level==0 (underflow):
  - state_out<=FAULT_STATE, fault<=1, fault_code<=2.
- HALT: halted<=1. state_out is unchanged.
- Illegal cmd: state_out<=FAULT_STATE, fault<=1, fault_code<=3.
- step_pulse=1 in the cycle after any accepted NEXT, CALL, RET or HALT, including a command that faults. After that the freeze rules apply.
- stack_top tracks stack[stack_level-1] after every update. It is 0 when stack_level is 0.
- CALL and RET may be issued back to back.
- CALL immediately followed by RET returns to cmd_ret and restores the previous level.
- Every state code, including FAULT_STATE, is a legal cmd_target. No range check is applied.

Test Plan:
1. rst=1 for 2 cycles, with cmd=CALL held -> state_out=0, stack_level=0, fault=0, step_pulse=0. After release, the first CALL (target 8'h10, ret 8'h05) gives state_out=8'h10, stack_level=1, stack_top=8'h05.
2. With DEPTH=4, nested CALLs: targets 10/20/30/40, rets 1/2/3/4. Then 4 RETs -> state_out goes 4, 3, 2, 1 and stack_level goes 3, 2, 1, 0. Then one more RET -> state_out=8'hFF, fault=1, fault_code=2.
3. Fill the stack with 4 CALLs, then a 5th CALL -> state_out=8'hFF, fault_code=1, stack_level stays 4. Subsequent NEXT commands are ignored until rst.
4. Assert stall during a CALL for 3 cycles -> state_out, stack_level and step_pulse are frozen. On the cycle after stall drops, the CALL is applied exactly once.
5. NEXT to 8'h22, then HALT, then NEXT to 8'h33 -> state_out stays 8'h22, halted=1. Then rst -> state_out=0, halted=0.
6. cmd=3'b110 -> fault_code=3, state_out=8'hFF, step_pulse is high for 1 cycle. Then assert rst with stack_level=2 -> stack_level=0, fault=0.

Source files
------------

// File: rtl/cpu_useq.sv
// cpu_useq: control-state register and hardware return stack for the CPU
// sequencer. The decoder drives one command per cycle, and the sequencer
// registers the next control state, which feeds back to decode and debug.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd                       000 HOLD, 001 NEXT, 010 CALL, 011 RET, 100 HALT
//   cmd_target, cmd_ret       jump destination and the return state to push
//   stall                     motherboard busy, freezes the sequencer
//   state_out                 current control state
//   stack_level, stack_top    return-stack occupancy and top entry
//   halted, fault, fault_code sticky status (fault code 1 ovf, 2 unf, 3 illegal)
//   step_pulse                one cycle high per accepted non-HOLD command
module cpu_useq #(
    parameter int                     STATE_WIDTH = 8,
    parameter int                     STACK_DEPTH = 4,
    parameter logic [STATE_WIDTH-1:0] RESET_STATE = '0,
    parameter logic [STATE_WIDTH-1:0] FAULT_STATE = 8'hFF,
    parameter int                     LEVEL_WIDTH = $clog2(STACK_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             cmd,
    input  logic [STATE_WIDTH-1:0] cmd_target,
    input  logic [STATE_WIDTH-1:0] cmd_ret,
    input  logic                   stall,
    output logic [STATE_WIDTH-1:0] state_out,
    output logic [LEVEL_WIDTH-1:0] stack_level,
    output logic [STATE_WIDTH-1:0] stack_top,
    output logic                   halted,
    output logic                   fault,
    output logic [1:0]             fault_code,
    output logic                   step_pulse
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] C_HOLD = 3'b000;
    localparam logic [2:0] C_NEXT = 3'b001;
    localparam logic [2:0] C_CALL = 3'b010;
    localparam logic [2:0] C_RET  = 3'b011;
    localparam logic [2:0] C_HALT = 3'b100;

    localparam logic [LEVEL_WIDTH-1:0] FULL = LEVEL_WIDTH'(STACK_DEPTH);

    logic [STATE_WIDTH-1:0] stack_q [2**IDX_W];

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [STATE_WIDTH-1:0] top_q, top_d;
    logic                   halted_q, halted_d;
    logic                   fault_q, fault_d;
    logic [1:0]             code_q, code_d;
    logic                   step_q, step_d;
    logic                   push;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        top_d    = top_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        code_d   = code_q;
        step_d   = 1'b0;
        push     = 1'b0;
        if (!fault_q && !halted_q && !stall) begin
            unique case (cmd)
                C_HOLD: begin
                end
                C_NEXT: begin
                    state_d = cmd_target;
                    step_d  = 1'b1;
                end
                C_CALL: begin
                    step_d = 1'b1;
                    if (level_q == FULL) begin
                        state_d = FAULT_STATE;
                        fault_d = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        push    = 1'b1;
                        level_d = level_q + 1'b1;
                        state_d = cmd_target;
                        top_d   = cmd_ret;
                    end
                end
                C_RET: begin
                    step_d = 1'b1;
                    if (level_q == '0) begin
                        state_d = FAULT_STATE;
                        fault_d = 1'b1;
                        code_d  = 2'd2;
                    end else begin
                        // top_q already mirrors stack[level-1]
                        state_d = top_q;
                        level_d = level_q - 1'b1;
                        if (level_q == LEVEL_WIDTH'(1))
                            top_d = '0;
                        else
                            top_d = stack_q[IDX_W'(level_q - LEVEL_WIDTH'(2))];
                    end
                end
                C_HALT: begin
                    halted_d = 1'b1;
                    step_d   = 1'b1;
                end
                default: begin
                    state_d = FAULT_STATE;
                    fault_d = 1'b1;
                    code_d  = 2'd3;
                    step_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RESET_STATE;
            level_q  <= '0;
            top_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 2'd0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            top_q    <= top_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            step_q   <= step_d;
        end
    end

    // Stack RAM has no reset; entries above the level are never read.
    always_ff @(posedge clk) begin
        if (!rst && push)
            stack_q[IDX_W'(level_q)] <= cmd_ret;
    end

    assign state_out   = state_q;
    assign stack_level = level_q;
    assign stack_top   = top_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign step_pulse  = step_q;

endmodule

// File: tb/tb_cpu_useq.sv
// tb_cpu_useq: directed vector table for the call/return corner cases,
// followed by random traffic compared against a queue-based reference model.
module tb_cpu_useq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cmd = 3'd0;
    logic [7:0] cmd_target = 8'd0;
    logic [7:0] cmd_ret = 8'd0;
    logic       stall = 1'b0;
    logic [7:0] state_out;
    logic [2:0] stack_level;
    logic [7:0] stack_top;
    logic       halted, fault, step_pulse;
    logic [1:0] fault_code;

    cpu_useq dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_target(cmd_target),
        .cmd_ret(cmd_ret), .stall(stall), .state_out(state_out),
        .stack_level(stack_level), .stack_top(stack_top), .halted(halted),
        .fault(fault), .fault_code(fault_code), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the stack is a plain queue of return states.
    int m_state = 0;
    int m_stack[$];
    bit m_halt = 0, m_fault = 0, m_step = 0;
    int m_code = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model(input bit r, input int c, input int t, input int rt,
                         input bit s);
        if (r) begin
            m_state = 0; m_stack.delete();
            m_halt = 0; m_fault = 0; m_code = 0; m_step = 0;
            return;
        end
        m_step = 0;
        if (m_fault || m_halt || s) return;
        case (c)
            0: ;
            1: begin m_state = t; m_step = 1; end
            2: begin
                m_step = 1;
                if (m_stack.size() == 4) begin
                    m_state = 255; m_fault = 1; m_code = 1;
                end else begin
                    m_stack.push_back(rt); m_state = t;
                end
            end
            3: begin
                m_step = 1;
                if (m_stack.size() == 0) begin
                    m_state = 255; m_fault = 1; m_code = 2;
                end else m_state = m_stack.pop_back();
            end
            4: begin m_halt = 1; m_step = 1; end
            default: begin
                m_state = 255; m_fault = 1; m_code = 3; m_step = 1;
            end
        endcase
    endtask

    task automatic cyc(input bit r, input int c, input int t, input int rt,
                       input bit s);
        rst = r; cmd = 3'(c); cmd_target = 8'(t); cmd_ret = 8'(rt); stall = s;
        @(posedge clk);
        model(r, c, t, rt, s);
        #1;
        chk("m_state", int'(state_out), m_state);
        chk("m_level", int'(stack_level), m_stack.size());
        chk("m_top", int'(stack_top), m_stack.size() ? m_stack[$] : 0);
        chk("m_halted", int'(halted), int'(m_halt));
        chk("m_fault", int'(fault), int'(m_fault));
        chk("m_code", int'(fault_code), m_code);
        chk("m_step", int'(step_pulse), int'(m_step));
    endtask

    typedef struct {
        bit r; int c; int t; int rt; bit s;
        int st; int lv; int top; bit h; bit f; int code; bit stp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit r, int c, int t, int rt, bit s, int st,
                                int lv, int top, bit h, bit f, int code,
                                bit stp);
        vec_t v;
        v.r = r; v.c = c; v.t = t; v.rt = rt; v.s = s;
        v.st = st; v.lv = lv; v.top = top; v.h = h; v.f = f;
        v.code = code; v.stp = stp;
        return v;
    endfunction

    task automatic rst_row();
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic fill4();
        vq.push_back(mk(0, 2, 'h10, 1, 0, 'h10, 1, 1, 0, 0, 0, 1));
        vq.push_back(mk(0, 2, 'h20, 2, 0, 'h20, 2, 2, 0, 0, 0, 1));
        vq.push_back(mk(0, 2, 'h30, 3, 0, 'h30, 3, 3, 0, 0, 0, 1));
        vq.push_back(mk(0, 2, 'h40, 4, 0, 'h40, 4, 4, 0, 0, 0, 1));
    endtask

    initial begin
        // reset with CALL held, then first CALL
        vq.push_back(mk(1, 2, 'h10, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 2, 'h10, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 'h10, 5, 0, 'h10, 1, 5, 0, 0, 0, 1));
        // nested calls, unwind, underflow
        rst_row();
        fill4();
        vq.push_back(mk(0, 3, 0, 0, 0, 4, 3, 3, 0, 0, 0, 1));
        vq.push_back(mk(0, 3, 0, 0, 0, 3, 2, 2, 0, 0, 0, 1));
        vq.push_back(mk(0, 3, 0, 0, 0, 2, 1, 1, 0, 0, 0, 1));
        vq.push_back(mk(0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 3, 0, 0, 0, 'hFF, 0, 0, 0, 1, 2, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 'hFF, 0, 0, 0, 1, 2, 0));
        // overflow, then NEXT ignored
        rst_row();
        fill4();
        vq.push_back(mk(0, 2, 'h50, 5, 0, 'hFF, 4, 4, 0, 1, 1, 1));
        vq.push_back(mk(0, 1, 'h77, 0, 0, 'hFF, 4, 4, 0, 1, 1, 0));
        vq.push_back(mk(0, 1, 'h78, 0, 0, 'hFF, 4, 4, 0, 1, 1, 0));
        // stall during CALL
        rst_row();
        vq.push_back(mk(0, 2, 'h10, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 'h10, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 'h10, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 2, 'h10, 5, 0, 'h10, 1, 5, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 'h10, 1, 5, 0, 0, 0, 0));
        // CALL then RET back to back
        vq.push_back(mk(0, 2, 'h60, 'h66, 0, 'h60, 2, 'h66, 0, 0, 0, 1));
        vq.push_back(mk(0, 3, 0, 0, 0, 'h66, 1, 5, 0, 0, 0, 1));
        // halt
        rst_row();
        vq.push_back(mk(0, 1, 'h22, 0, 0, 'h22, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 4, 0, 0, 0, 'h22, 0, 0, 1, 0, 0, 1));
        vq.push_back(mk(0, 1, 'h33, 0, 0, 'h22, 0, 0, 1, 0, 0, 0));
        rst_row();
        // FAULT_STATE as a plain NEXT target
        vq.push_back(mk(0, 1, 'hFF, 0, 0, 'hFF, 0, 0, 0, 0, 0, 1));
        // illegal command
        vq.push_back(mk(0, 6, 0, 0, 0, 'hFF, 0, 0, 0, 1, 3, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 'hFF, 0, 0, 0, 1, 3, 0));
        rst_row();
        vq.push_back(mk(0, 5, 0, 0, 0, 'hFF, 0, 0, 0, 1, 3, 1));
        // reset with two entries on the stack
        rst_row();
        vq.push_back(mk(0, 2, 'h10, 1, 0, 'h10, 1, 1, 0, 0, 0, 1));
        vq.push_back(mk(0, 2, 'h20, 2, 0, 'h20, 2, 2, 0, 0, 0, 1));
        rst_row();

        foreach (vq[i]) begin
            cyc(vq[i].r, vq[i].c, vq[i].t, vq[i].rt, vq[i].s);
            chk($sformatf("v%0d_state", i), int'(state_out), vq[i].st);
            chk($sformatf("v%0d_level", i), int'(stack_level), vq[i].lv);
            chk($sformatf("v%0d_top", i), int'(stack_top), vq[i].top);
            chk($sformatf("v%0d_halted", i), int'(halted), int'(vq[i].h));
            chk($sformatf("v%0d_fault", i), int'(fault), int'(vq[i].f));
            chk($sformatf("v%0d_code", i), int'(fault_code), vq[i].code);
            chk($sformatf("v%0d_step", i), int'(step_pulse), int'(vq[i].stp));
        end

        // random traffic
        cyc(1, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            int c, w;
            w = $urandom_range(0, 99);
            if (w < 25)      c = 2;
            else if (w < 45) c = 3;
            else if (w < 70) c = 1;
            else if (w < 90) c = 0;
            else if (w < 95) c = 4;
            else             c = $urandom_range(5, 7);
            cyc($urandom_range(0, 19) == 0, c, $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 4) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
